// File: rtl/I2cPackage.sv
// Shared types for the write-only I2C target receiver.
// No logic; state encoding and FIFO entry layout only.
// Not applicable: no handshake lives here.
package I2cPackage;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } I2cTargetState_enum;

  // start marks the first data byte after an address ACK (display control byte)
  typedef struct packed {
    logic       start;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO, generic over depth and entry type.
// Head is combinational from storage; push/pop take effect on the clk edge.
// Push refused when full unless a pop lands on the same edge; pop on empty ignored.
module rx_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [8:0]
) (
  input  logic   clk,
  input  logic   n_reset,
  input  logic   push,
  input  entry_t push_dat,
  input  logic   pop,
  output entry_t head_dat,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; reset empties the FIFO and clears storage.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: START/STOP decode, address match, ACK, byte queue.
// Pin-to-action SYNC_STAGES+1 clks; push SYNC_STAGES+2 after raw 8th SCL rise.
// Consumer pops via rx_pop; a byte arriving to a full FIFO is NACKed and flagged.
module i2c_target_rx
  import I2cPackage::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h3C,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       SCL,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  output logic [7:0] rx_data,
  output logic       rx_start,
  output logic       rx_valid,
  input  logic       rx_pop,
  output logic       busy,
  output logic       overflow,
  input  logic       clear_overflow
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  I2cTargetState_enum     state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   byte_done_q, byte_done_d;
  logic                   push_req_q, push_req_d;
  logic                   accepted_q, accepted_d;
  logic                   first_q, first_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;
  logic                   sda_out_q, sda_out_d;

  logic      scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic      fifo_full, fifo_empty, push_ok;
  rx_entry_t push_entry, head_entry;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be steadily high so a clock edge is never taken as START/STOP
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign push_ok          = ~fifo_full | rx_pop;
  assign push_entry.start = first_q;
  assign push_entry.data  = shift_q;

  assign SDA_OUT  = sda_out_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign rx_valid = ~fifo_empty;
  assign rx_data  = rx_valid ? head_entry.data : 8'h00;
  assign rx_start = rx_valid & head_entry.start;

  // Pin synchronizers plus one extra copy of the last stage for edge detect.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Protocol FSM, deferred FIFO push and ACK drive; START/STOP override everything.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    push_req_d  = 1'b0;
    accepted_d  = accepted_q;
    first_d     = first_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    // registered from state so the line moves one clk after the state does
    sda_out_d   = ~((state_q == ADDR_ACK) || (state_q == DATA_ACK));

    if (clear_overflow) overflow_d = 1'b0;

    // the push lands one clk after the 8th bit; its outcome picks ACK or NACK
    if (push_req_q) begin
      accepted_d = push_ok;
      if (push_ok) first_d = 1'b0;
      else         overflow_d = 1'b1;
    end

    if (stop_det) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              push_req_d  = (state_q == DATA);
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd0;
            if (state_q == ADDR) begin
              if ((shift_q[7:1] == ADDRESS) && !shift_q[0]) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                first_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              state_d = accepted_q ? DATA_ACK : IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) state_d = DATA;
        end
        default: ;
      endcase
    end
  end

  // All target state; reset releases SDA at once and idles the bus view high.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      push_req_q  <= 1'b0;
      accepted_q  <= 1'b0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      sda_out_q   <= 1'b1;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      push_req_q  <= push_req_d;
      accepted_q  <= accepted_d;
      first_q     <= first_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      sda_out_q   <= sda_out_d;
    end
  end

  rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .entry_t(rx_entry_t)
  ) u_rx_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push_req_q),
    .push_dat(push_entry),
    .pop     (rx_pop),
    .head_dat(head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master with open-drain wire model.
// Expected FIFO entries are queued as bytes are sent and compared when drained.
// Bus edges are placed on clk falling edges so push timing is deterministic.
module tb_i2c_target_rx;
  import I2cPackage::*;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_pop = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       sda_out, rx_start, rx_valid, busy, overflow;
  logic [7:0] rx_data;
  logic       sda_line;
  logic       ack;
  int         n_checks = 0;
  int         n_errors = 0;
  int         low_cnt = 0;
  int         low_snap;
  rx_entry_t  exp_q [$];

  assign sda_line = sda_m & sda_out;

  always #5 clk = ~clk;

  i2c_target_rx #(
    .ADDRESS    (7'h3C),
    .FIFO_DEPTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .SCL           (scl),
    .SDA_IN        (sda_line),
    .SDA_OUT       (sda_out),
    .rx_data       (rx_data),
    .rx_start      (rx_start),
    .rx_valid      (rx_valid),
    .rx_pop        (rx_pop),
    .busy          (busy),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always @(negedge clk) if (!sda_out) low_cnt <= low_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_push(input logic st, input logic [7:0] d);
    rx_entry_t e;
    e.start = st;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic i2c_start();
    @(negedge clk); sda_m = 1'b1;
    repeat (4) @(negedge clk); scl = 1'b1;
    repeat (4) @(negedge clk); sda_m = 1'b0;
    repeat (4) @(negedge clk); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    @(negedge clk); sda_m = 1'b0;
    repeat (4) @(negedge clk); scl = 1'b1;
    repeat (4) @(negedge clk); sda_m = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    repeat (2) @(negedge clk); sda_m = b;
    repeat (6) @(negedge clk); scl = 1'b1;
    repeat (8) @(negedge clk); scl = 1'b0;
  endtask

  task automatic read_ack(output logic a);
    repeat (2) @(negedge clk); sda_m = 1'b1;
    repeat (6) @(negedge clk); scl = 1'b1;
    repeat (4) @(negedge clk); a = ~sda_line;
    repeat (4) @(negedge clk); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_ack(a);
  endtask

  // Last bit raises SCL, then the head is popped on the very clk the push lands.
  task automatic send_byte_pop(input logic [7:0] d, output logic a);
    rx_entry_t e;
    for (int i = 7; i >= 1; i--) send_bit(d[i]);
    repeat (2) @(negedge clk); sda_m = d[0];
    repeat (6) @(negedge clk); scl = 1'b1;
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    check("pop_push_head_start", 32'(rx_start), 32'(e.start));
    check("pop_push_head_data", 32'(rx_data), 32'(e.data));
    rx_pop = 1'b1;
    @(negedge clk); rx_pop = 1'b0;
    repeat (4) @(negedge clk); scl = 1'b0;
    read_ack(a);
  endtask

  task automatic drain(input string tag);
    rx_entry_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!rx_valid) break;
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'(rx_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_start"}, 32'(rx_start), 32'(e.start));
        check({tag, "_data"}, 32'(rx_data), 32'(e.data));
      end
      rx_pop = 1'b1;
      @(negedge clk); rx_pop = 1'b0;
    end
    check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_after"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 n_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sda_out", 32'(sda_out), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_start", 32'(rx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);

    // basic write: address, control byte, data byte
    i2c_start();
    send_byte(8'h78, ack); check("t1_addr_ack", 32'(ack), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h00, ack); check("t1_d0_ack", 32'(ack), 32'd1); expect_push(1'b1, 8'h00);
    send_byte(8'hAF, ack); check("t1_d1_ack", 32'(ack), 32'd1); expect_push(1'b0, 8'hAF);
    i2c_stop();
    check("t1_busy_stop", 32'(busy), 32'd0);
    drain("t1");

    // wrong address: NACK, following byte ignored
    i2c_start();
    send_byte(8'h7A, ack); check("t2_addr_nack", 32'(ack), 32'd0);
    send_byte(8'hFF, ack); check("t2_data_nack", 32'(ack), 32'd0);
    check("t2_state", 32'(dut.state_q), 32'(IGNORE));
    check("t2_rx_valid", 32'(rx_valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    i2c_stop();
    check("t2_state_stop", 32'(dut.state_q), 32'(IDLE));

    // read bit set: NACK, SDA_OUT never pulled through the next byte
    low_snap = low_cnt;
    i2c_start();
    send_byte(8'h79, ack); check("t3_addr_nack", 32'(ack), 32'd0);
    send_byte(8'h55, ack);
    check("t3_sda_never_low", 32'(low_cnt - low_snap), 32'd0);
    i2c_stop();

    // overflow: four bytes fit, fifth is NACKed and dropped
    i2c_start();
    send_byte(8'h78, ack); check("t4_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h11 * (i + 1), ack);
      check("t4_fill_ack", 32'(ack), 32'd1);
      expect_push(i == 0, 8'(8'h11 * (i + 1)));
    end
    send_byte(8'h55, ack); check("t4_full_nack", 32'(ack), 32'd0);
    check("t4_overflow", 32'(overflow), 32'd1);
    i2c_stop();
    drain("t4");
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    @(negedge clk); clear_overflow = 1'b1;
    @(negedge clk); clear_overflow = 1'b0;
    check("t4_overflow_clr", 32'(overflow), 32'd0);

    // repeated START after three bits restarts the address byte
    i2c_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_start();
    send_byte(8'h78, ack); check("t5_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h40, ack); check("t5_data_ack", 32'(ack), 32'd1); expect_push(1'b1, 8'h40);
    i2c_stop();
    drain("t5");

    // full FIFO with pop and push on the same clk
    i2c_start();
    send_byte(8'h78, ack); check("t6_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hA1 + 8'(i), ack);
      check("t6_fill_ack", 32'(ack), 32'd1);
      expect_push(i == 0, 8'hA1 + 8'(i));
    end
    expect_push(1'b0, 8'hA5);
    send_byte_pop(8'hA5, ack);
    check("t6_popped_push_ack", 32'(ack), 32'd1);
    check("t6_no_overflow", 32'(overflow), 32'd0);
    i2c_stop();
    drain("t6");

    // reset during a data ACK releases SDA immediately and empties the FIFO
    i2c_start();
    send_byte(8'h78, ack); check("t7_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h12, ack); check("t7_d0_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 0; i--) send_bit(8'h34 >> i);
    repeat (2) @(negedge clk); sda_m = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_ack_drive", 32'(sda_out), 32'd0);
    check("t7_valid_pre", 32'(rx_valid), 32'd1);
    n_reset = 1'b0;
    #1;
    check("t7_rst_sda", 32'(sda_out), 32'd1);
    check("t7_rst_valid", 32'(rx_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); scl = 1'b1;
    repeat (4) @(negedge clk); n_reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_post_sda", 32'(sda_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
